// File: rtl/led_flow_ctrl_if.sv
// Control/drive bundle between the step source and the LED pattern engine.
// The source drives tick/en/mode; the engine drives led/step.
interface led_flow_ctrl_if #(
    parameter int LED_W = 4
);
    logic             tick;
    logic             en;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             step;

    modport master (
        output tick, en, mode,
        input  led, step
    );

    modport slave (
        input  tick, en, mode,
        output led, step
    );
endinterface

// File: rtl/led_flow_ctrl.sv
// LED pattern engine: blink, rotate left/right and ping-pong,
// advanced by divided ticks, active-low registered LED drive.
module led_flow_ctrl #(
    parameter int LED_W    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic           clk_50M,
    input  logic           rst,
    led_flow_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [LED_W-1:0] p_q, p_d;
    logic             dir_q, dir_d;
    logic [7:0]       div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic [LED_W-1:0] led_d;
    logic             adv;

    function automatic logic [LED_W-1:0] init_pat(input logic [1:0] m);
        logic [LED_W-1:0] r;
        unique case (m)
            2'd0:    r = '0;
            2'd2:    r = {1'b1, {(LED_W-1){1'b0}}};
            default: r = {{(LED_W-1){1'b0}}, 1'b1};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        dir_d   = dir_q;
        div_d   = div_q;
        mode_d  = mode_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    dir_d   = 1'b0;
                    p_d     = init_pat(bus.mode);
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else if (bus.mode != mode_q) begin
                    // reload swallows any tick in this cycle
                    mode_d = bus.mode;
                    div_d  = '0;
                    dir_d  = 1'b0;
                    p_d    = init_pat(bus.mode);
                end else if (bus.tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        adv   = 1'b1;
                        unique case (mode_q)
                            2'd0: p_d = ~p_q;
                            2'd1: p_d = {p_q[LED_W-2:0], p_q[LED_W-1]};
                            2'd2: p_d = {p_q[0], p_q[LED_W-1:1]};
                            default: begin
                                if (!dir_q && p_q[LED_W-1]) begin
                                    dir_d = 1'b1;
                                    p_d   = p_q >> 1;
                                end else if (dir_q && p_q[0]) begin
                                    dir_d = 1'b0;
                                    p_d   = p_q << 1;
                                end else if (dir_q) begin
                                    p_d = p_q >> 1;
                                end else begin
                                    p_d = p_q << 1;
                                end
                            end
                        endcase
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        led_d = (state_d == RUN) ? ~p_d : '1;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            dir_q    <= 1'b0;
            div_q    <= '0;
            mode_q   <= '0;
            bus.led  <= '1;
            bus.step <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            dir_q    <= dir_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            bus.led  <= led_d;
            bus.step <= adv;
        end
    end
endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench: two engines (divide-by-1 and divide-by-3)
// share one stimulus stream; expectations are hand-computed.
module tb_led_flow_ctrl;
    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    int         total = 0;
    int         bad = 0;

    always #10 clk_50M = ~clk_50M;

    led_flow_ctrl_if #(.LED_W(4)) b1 ();
    led_flow_ctrl_if #(.LED_W(4)) b3 ();

    assign b1.tick = tick;
    assign b1.en   = en;
    assign b1.mode = mode;
    assign b3.tick = tick;
    assign b3.en   = en;
    assign b3.mode = mode;

    led_flow_ctrl #(.LED_W(4), .TICK_DIV(1)) dut1 (
        .clk_50M(clk_50M),
        .rst    (rst),
        .bus    (b1)
    );

    led_flow_ctrl #(.LED_W(4), .TICK_DIV(3)) dut3 (
        .clk_50M(clk_50M),
        .rst    (rst),
        .bus    (b3)
    );

    task automatic cyc();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        tick = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en   = 1'b1;
        tick = 1'b1;
        mode = 2'd1;
        cyc();
        total++;
        if (b1.led !== 4'b1111 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL reset1 led=%b step=%b exp=1111/0", b1.led, b1.step);
        end
        total++;
        if (b3.led !== 4'b1111 || b3.step !== 1'b0) begin
            bad++;
            $display("FAIL reset3 led=%b step=%b exp=1111/0", b3.led, b3.step);
        end
        en   = 1'b0;
        tick = 1'b0;
        rst  = 1'b0;
        // idle must ignore ticks
        tick = 1'b1;
        cyc();
        cyc();
        total++;
        if (b1.led !== 4'b1111 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL idle_tick led=%b step=%b exp=1111/0", b1.led, b1.step);
        end
        tick = 1'b0;
    endtask

    task automatic test_rotate_left();
        logic [3:0] exp_led [5] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        do_reset();
        en   = 1'b1;
        mode = 2'd1;
        cyc();
        total++;
        if (b1.led !== 4'b1110 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL rol_init led=%b step=%b exp=1110/0", b1.led, b1.step);
        end
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++;
            if (b1.led !== exp_led[i] || b1.step !== 1'b1) begin
                bad++;
                $display("FAIL rol_%0d led=%b step=%b exp=%b/1", i, b1.led, b1.step, exp_led[i]);
            end
        end
        tick = 1'b0;
        cyc();
        total++;
        if (b1.led !== 4'b1101 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL rol_hold led=%b step=%b exp=1101/0", b1.led, b1.step);
        end
    endtask

    task automatic test_ping_pong();
        logic [3:0] exp_led [8] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011,
                                    4'b1101, 4'b1110, 4'b1101, 4'b1011};
        do_reset();
        en   = 1'b1;
        mode = 2'd3;
        cyc();
        total++;
        if (b1.led !== 4'b1110) begin
            bad++;
            $display("FAIL pp_init led=%b exp=1110", b1.led);
        end
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            total++;
            if (b1.led !== exp_led[i] || b1.step !== 1'b1) begin
                bad++;
                $display("FAIL pp_%0d led=%b step=%b exp=%b/1", i, b1.led, b1.step, exp_led[i]);
            end
        end
        tick = 1'b0;
        cyc();
        total++;
        if (b1.step !== 1'b0) begin
            bad++;
            $display("FAIL pp_step_low step=%b exp=0", b1.step);
        end
    endtask

    task automatic test_divider();
        logic [3:0] exp_led [6] = '{4'b1111, 4'b1111, 4'b0000,
                                    4'b0000, 4'b0000, 4'b1111};
        logic       exp_stp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int         steps = 0;
        do_reset();
        en   = 1'b1;
        mode = 2'd0;
        cyc();
        total++;
        if (b3.led !== 4'b1111) begin
            bad++;
            $display("FAIL div_init led=%b exp=1111", b3.led);
        end
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            steps += int'(b3.step);
            total++;
            if (b3.led !== exp_led[i] || b3.step !== exp_stp[i]) begin
                bad++;
                $display("FAIL div_%0d led=%b step=%b exp=%b/%b", i, b3.led, b3.step, exp_led[i], exp_stp[i]);
            end
        end
        tick = 1'b0;
        total++;
        if (steps != 2) begin
            bad++;
            $display("FAIL div_steps got=%0d exp=2", steps);
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        en   = 1'b1;
        mode = 2'd1;
        cyc();
        mode = 2'd2;
        tick = 1'b1;
        cyc();
        total++;
        if (b1.led !== 4'b0111 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL mchg_reload led=%b step=%b exp=0111/0", b1.led, b1.step);
        end
        cyc();
        total++;
        if (b1.led !== 4'b1011 || b1.step !== 1'b1) begin
            bad++;
            $display("FAIL mchg_next led=%b step=%b exp=1011/1", b1.led, b1.step);
        end
        tick = 1'b0;
    endtask

    task automatic test_en_drop();
        en   = 1'b0;
        tick = 1'b1;
        cyc();
        total++;
        if (b1.led !== 4'b1111 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL endrop led=%b step=%b exp=1111/0", b1.led, b1.step);
        end
        tick = 1'b0;
        en   = 1'b1;
        cyc();
        total++;
        if (b1.led !== 4'b0111 || b1.step !== 1'b0) begin
            bad++;
            $display("FAIL enrise led=%b step=%b exp=0111/0", b1.led, b1.step);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en   = 1'b1;
        mode = 2'd1;
        cyc();
        tick = 1'b1;
        cyc();
        cyc();
        total++;
        if (b3.led !== 4'b1110 || b3.step !== 1'b0) begin
            bad++;
            $display("FAIL rmid_pre led=%b step=%b exp=1110/0", b3.led, b3.step);
        end
        tick = 1'b0;
        rst  = 1'b1;
        cyc();
        total++;
        if (b3.led !== 4'b1111 || b3.step !== 1'b0) begin
            bad++;
            $display("FAIL rmid_rst led=%b step=%b exp=1111/0", b3.led, b3.step);
        end
        rst = 1'b0;
        cyc();
        total++;
        if (b3.led !== 4'b1110) begin
            bad++;
            $display("FAIL rmid_restart led=%b exp=1110", b3.led);
        end
        tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (b3.led !== 4'b1110 || b3.step !== 1'b0) begin
                bad++;
                $display("FAIL rmid_wait%0d led=%b step=%b exp=1110/0", i, b3.led, b3.step);
            end
        end
        cyc();
        total++;
        if (b3.led !== 4'b1101 || b3.step !== 1'b1) begin
            bad++;
            $display("FAIL rmid_adv led=%b step=%b exp=1101/1", b3.led, b3.step);
        end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_ping_pong();
        test_divider();
        test_mode_change();
        test_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
